debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the dff block and drives its d input.
//  Synchronises an asynchronous, possibly bouncing input d_in into the clk domain.
//  Filters out pulses shorter than STABLE_CYCLES and presents a clean level q.
//  Also emits single-cycle rise/fall strobes, so downstream flip-flops never see metastable or glitchy data.
// PARAMETERS
//  SYNC_STAGES    2   number of synchroniser flops (>=2)
//  CNT_W          4   stability counter width (bits)
//  STABLE_CYCLES  10  consecutive synchronised cycles required before q changes (2 .. 2^CNT_W-1)
// PORTS
//  clk    in   1  single clock; all state updates on posedge clk
//  reset  in   1  asynchronous, active-high reset
//  d_in   in   1  raw asynchronous input (switch, external pin)
//  q      out  1  debounced, synchronised level (feeds dff d)
//  rise   out  1  one-cycle strobe: q went 0->1 this cycle
//  fall   out  1  one-cycle strobe: q went 1->0 this cycle
//  busy   out  1  high while a candidate transition is being qualified
// BEHAVIOUR
//  Reset: async, active-high; while reset=1 all sync flops=0, cnt=0, state=IDLE, q=0, rise=0, fall=0, busy=0.
//  Synchroniser: d_in shifts through SYNC_STAGES flops; s = last stage; s lags d_in by SYNC_STAGES edges.
//  FSM, 2 states, all outputs registered:
//   IDLE  (busy=0): s==q -> stay. s!=q -> COUNT, cnt<=1.
//   COUNT (busy=1): s==q -> IDLE, cnt<=0, q unchanged (glitch rejected, no strobe).
//                   s!=q and cnt==STABLE_CYCLES-1 -> q<=s, rise<=s, fall<=~s, IDLE, cnt<=0.
//                   s!=q otherwise -> cnt<=cnt+1.
//  Latency: a clean d_in step is reflected on q after exactly SYNC_STAGES+STABLE_CYCLES posedges (12 at defaults).
//  rise/fall assert in the same cycle q changes, for exactly one cycle; never both high.
//  Counter never wraps. Parameter violation (STABLE_CYCLES<2 or >2^CNT_W-1, SYNC_STAGES<2) is an
//   elaboration-time error.
//  Input toggling with period < STABLE_CYCLES cycles: q holds its value indefinitely, no strobes.
//  Reset mid-count: candidate discarded immediately (async); after release a full SYNC_STAGES+STABLE_CYCLES is required.
//  d_in changing between samples is legal; metastability is confined to sync stage 1.
// STRUCTURE
//  Shared header debounce_defs.vh: state encodings ST_IDLE=1'b0, ST_COUNT=1'b1.
//  Shared header debounce_defs.vh: default parameter values.
//  One sub-module: sync_chain (parameterised N-stage synchroniser, clk/reset/d/q), reusable elsewhere.
//  Top: sync_chain instance + FSM/counter + output registers.
// TESTING  (defaults, clk period 10, d_in changed mid-period)
//  1 Reset: reset=1, d_in=1 for 5 cycles -> q=0, rise=0, fall=0, busy=0 throughout.
//  2 Clean rise: d_in 0->1 held 20 cycles -> busy=1 from edge 3 to edge 11; q=1 and rise=1 after edge 12.
//    rise=0 again after edge 13; fall stays 0.
//  3 Glitch: d_in=1 for 5 cycles then 0 -> q stays 0, rise never 1, busy returns 0.
//  4 Clean fall: from q=1, d_in 1->0 held 20 cycles -> q=0 and fall=1 for one cycle after edge 12.
//  5 Chatter: d_in toggles every cycle for 50 cycles -> q, rise, fall constant 0.
//    Also toggling every 5 cycles -> q, rise, fall constant 0.
//  6 Reset mid-count: d_in 0->1, reset pulse at edge 8 -> busy=0, q=0 at once.
//    After release with d_in=1, q=1 only after 12 further edges.

Source files
------------

// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debounce/synchroniser block.
// Holds the FSM state encoding and the default parameter values.
package debounce_sync_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_CNT_W         = 4;
    localparam int DEF_STABLE_CYCLES = 10;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Parameterised N-stage synchroniser for a single-bit asynchronous input.
// Any metastability is confined to the first stage. Reusable on its own.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronises d_in, then only accepts a new level once it has been
// stable for STABLE_CYCLES cycles. Produces a clean q plus one-cycle rise/fall strobes.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    // An unusable parameter set must stop elaboration rather than build a broken counter.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES must lie in 2 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (d_in),
        .q    (s)
    );

    // The counter stops at LAST_CNT, so it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s != q) begin
                        state <= ST_COUNT;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (s == q) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        q     <= s;
                        rise  <= s;
                        fall  <= ~s;
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync at default parameters: table-driven vectors
// fed through a scoreboard queue, plus hand-written async-reset sequences.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic reset;
    logic d_in;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic d;
        logic rst;
        logic q;
        logic rise;
        logic fall;
        logic busy;
        logic chk_busy;
    } vec_t;

    vec_t exp_q[$];
    vec_t rise_tbl[20];
    vec_t fall_tbl[20];
    vec_t glitch_tbl[12];

    debounce_sync dut (
        .clk  (clk),
        .reset(reset),
        .d_in (d_in),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic d, input logic rst, input logic eq, input logic er,
                                input logic ef, input logic eb, input logic cb);
        vec_t v;
        v.d        = d;
        v.rst      = rst;
        v.q        = eq;
        v.rise     = er;
        v.fall     = ef;
        v.busy     = eb;
        v.chk_busy = cb;
        return v;
    endfunction

    // Expected outputs after edge e (1-based) following a clean step of d_in toward to_one.
    // Two sync edges, then ten counting edges: busy over edges 3..11, q flips on edge 12.
    function automatic vec_t step_vec(input int e, input logic to_one);
        return mk(to_one, 1'b0,
                  (e >= 12) ? to_one : ~to_one,
                  to_one && (e == 12),
                  !to_one && (e == 12),
                  (e >= 3) && (e <= 11),
                  1'b1);
    endfunction

    task automatic checkOutput(input string tag);
        vec_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got q=%b rise=%b fall=%b busy=%b",
                     tag, q, rise, fall, busy);
            return;
        end
        e = exp_q.pop_front();
        if (q !== e.q || rise !== e.rise || fall !== e.fall || (e.chk_busy && busy !== e.busy)) begin
            n_fail++;
            $display("[TB] FAIL %s: got q=%b rise=%b fall=%b busy=%b, expected q=%b rise=%b fall=%b busy=%b%s",
                     tag, q, rise, fall, busy, e.q, e.rise, e.fall, e.busy,
                     e.chk_busy ? "" : " (busy ignored)");
        end
    endtask

    // Drive mid-period, record the expectation, sample 1 time unit after the edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        d_in  = v.d;
        reset = v.rst;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkNow(input string tag, input logic eq, input logic er, input logic ef,
                            input logic eb);
        exp_q.push_back(mk(d_in, reset, eq, er, ef, eb, 1'b1));
        checkOutput(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got q=%b busy=%b", q, busy);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 20; i++) begin
            rise_tbl[i] = step_vec(i + 1, 1'b1);
            fall_tbl[i] = step_vec(i + 1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            glitch_tbl[i] = mk((i + 1) <= 5, 1'b0, 1'b0, 1'b0, 1'b0,
                               ((i + 1) >= 3) && ((i + 1) <= 7), 1'b1);
        end

        reset = 1'b1;
        d_in  = 1'b1;
        #1;
        checkNow("reset_t0", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++)
            applyStimulus(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "reset_hold");
        for (int i = 0; i < 3; i++)
            applyStimulus(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "reset_release");

        for (int i = 0; i < 20; i++)
            applyStimulus(rise_tbl[i], $sformatf("clean_rise_e%0d", i + 1));
        for (int i = 0; i < 20; i++)
            applyStimulus(fall_tbl[i], $sformatf("clean_fall_e%0d", i + 1));
        for (int i = 0; i < 12; i++)
            applyStimulus(glitch_tbl[i], $sformatf("glitch_e%0d", i + 1));

        for (int i = 0; i < 50; i++)
            applyStimulus(mk((i % 2) == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "chatter_1");
        for (int i = 0; i < 60; i++)
            applyStimulus(mk(((i / 5) % 2) == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "chatter_5");
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "settle");
        for (int i = 0; i < 2; i++)
            applyStimulus(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "settle_idle");

        // Reset arrives mid-qualification and must discard the candidate without a clock.
        for (int i = 0; i < 7; i++)
            applyStimulus(step_vec(i + 1, 1'b1), $sformatf("pre_reset_e%0d", i + 1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkNow("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkNow("reset_edge8", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(rise_tbl[i], $sformatf("post_reset_e%0d", i + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
